// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, drives the instruction memory address and
// buffers returned {pc, instr} pairs in a small FIFO feeding decode.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                pc_plus4_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic [31:0]   fetch_pc_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          head_valid_s;
    logic          pop_s;
    logic          push_s;

    assign head_valid_s = (count_r != CW'(0));
    assign pop_s        = head_valid_s & instr_ready_i;
    // A full queue can still accept a fetch when decode frees the head slot.
    assign push_s       = ~redirect_i & ((count_r < DEPTH_C) | pop_s);

    // Next-state for fetch PC, pointers and occupancy.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        count_nxt_s    = count_r;
        if (redirect_i) begin
            fetch_pc_nxt_s = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_nxt_s   = PW'(0);
            wr_ptr_nxt_s   = PW'(0);
            count_nxt_s    = CW'(0);
        end else begin
            if (push_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                wr_ptr_nxt_s   = wr_ptr_r + PW'(1);
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
                wr_ptr_nxt_s   = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= PW'(0);
            wr_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

    // Entry storage; contents are only observable through count, so no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_s) begin
            pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
            instr_mem_r[wr_ptr_r] <= imem_instr_i;
        end
    end

    // Head outputs come from registered state only, zeroed when empty.
    always_comb begin
        instr_valid_o = head_valid_s;
        count_o       = count_r;
        imem_addr_o   = fetch_pc_r;
        if (head_valid_s) begin
            instr_o    = instr_mem_r[rd_ptr_r];
            pc_o       = pc_mem_r[rd_ptr_r];
            pc_plus4_o = pc_mem_r[rd_ptr_r] + 32'd4;
        end else begin
            instr_o    = 32'd0;
            pc_o       = 32'd0;
            pc_plus4_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory word at byte address A is
// 32'h1000_0000 + A/4, except address 32'h200 which returns a zero word.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr == 32'h0000_0200) ? 32'd0
                                                     : 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .instr_ready_i (instr_ready),
        .count_o       (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_vec++; if ({instr, pc, pc_plus4} !== 96'd0) begin n_err++; $display("FAIL reset_data got %h %h %h want 0", instr, pc, pc_plus4); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        step();
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", instr_valid); end
        n_vec++; if (instr !== 32'h1000_0000) begin n_err++; $display("FAIL first_instr got %h want 10000000", instr); end
        n_vec++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin n_err++; $display("FAIL first_pc got %h/%h want 0/4", pc, pc_plus4); end
        for (int k = 1; k < 5; k++) begin
            step();
            n_vec++;
            if (pc !== 32'(4 * k) || instr !== 32'h1000_0000 + 32'(k) || count !== 3'd1 || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stream_%0d got pc=%h instr=%h cnt=%0d v=%b want pc=%h instr=%h cnt=1 v=1",
                         k, pc, instr, count, instr_valid, 32'(4 * k), 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++;
            if (count !== 3'((k > 4) ? 4 : k)) begin n_err++; $display("FAIL fill_count_%0d got %0d want %0d", k, count, (k > 4) ? 4 : k); end
        end
        n_vec++; if (imem_addr !== 32'h10 || pc !== 32'h0) begin n_err++; $display("FAIL full_hold got addr=%h pc=%h want 10/0", imem_addr, pc); end
        instr_ready = 1'b1;
        step();
        n_vec++; if (count !== 3'd4 || pc !== 32'h4 || imem_addr !== 32'h14) begin n_err++; $display("FAIL full_pop_push got cnt=%0d pc=%h addr=%h want 4/4/14", count, pc, imem_addr); end
        instr_ready = 1'b0;
        step();
        n_vec++; if (count !== 3'd4 || pc !== 32'h4) begin n_err++; $display("FAIL full_rehold got cnt=%0d pc=%h want 4/4", count, pc); end
        instr_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            n_vec++;
            if (pc !== 32'(4 * k) || instr !== 32'h1000_0000 + 32'(k) || count !== 3'd4) begin
                n_err++;
                $display("FAIL drain_%0d got pc=%h instr=%h cnt=%0d want pc=%h cnt=4", k, pc, instr, count, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0043; instr_ready = 1'b1;
        step();
        n_vec++; if (count !== 3'd0 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_flush got cnt=%0d v=%b addr=%h want 0/0/40", count, instr_valid, imem_addr); end
        n_vec++; if (instr !== 32'd0 || pc !== 32'd0) begin n_err++; $display("FAIL redir_empty_data got %h/%h want 0/0", instr, pc); end
        redirect = 1'b0;
        step();
        n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h40 || instr !== 32'h1000_0010) begin n_err++; $display("FAIL redir_target got v=%b pc=%h instr=%h want 1/40/10000010", instr_valid, pc, instr); end
        step();
        n_vec++; if (pc !== 32'h44) begin n_err++; $display("FAIL redir_next got %h want 44", pc); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_pc = 32'h0000_0202;
        step();
        n_vec++; if (imem_addr !== 32'h200 || count !== 3'd0) begin n_err++; $display("FAIL b2b_last_wins got addr=%h cnt=%0d want 200/0", imem_addr, count); end
        redirect = 1'b0;
        step();
        n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h200 || instr !== 32'd0) begin n_err++; $display("FAIL b2b_nop got v=%b pc=%h instr=%h want 1/200/0", instr_valid, pc, instr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(); step(); step();
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_prefill got %0d want 3", count); end
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; instr_ready = 1'b1;
        step();
        n_vec++; if (count !== 3'd0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_reset got cnt=%0d v=%b addr=%h want 0/0/0", count, instr_valid, imem_addr); end
        n_vec++; if ({instr, pc, pc_plus4} !== 96'd0) begin n_err++; $display("FAIL mid_reset_data got %h %h %h want 0", instr, pc, pc_plus4); end
        rst = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        step();
        n_vec++; if (pc !== 32'hFFFF_FFF8 || instr !== 32'h4FFF_FFFE) begin n_err++; $display("FAIL wrap_0 got pc=%h instr=%h want fffffff8/4ffffffe", pc, instr); end
        step();
        n_vec++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_1 got pc=%h p4=%h want fffffffc/0", pc, pc_plus4); end
        step();
        n_vec++; if (pc !== 32'h0 || instr !== 32'h1000_0000) begin n_err++; $display("FAIL wrap_2 got pc=%h instr=%h want 0/10000000", pc, instr); end
        step();
        n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL wrap_3 got %h want 4", pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage sitting directly upstream of the instruction memory and downstream-feeding the decode stage.
- Owns the fetch PC and drives the word address into the combinational instruction memory.
- Captures each returned instruction, together with its PC, into a small FIFO.
- Presents queued instructions to decode through a valid/ready handshake.
- Supports branch/jump redirect with a full queue flush.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, fetch PC after reset; low 2 bits must be 0.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- imem_addr_o  output  32  byte address to instruction memory; equals fetch_pc combinationally.
- imem_instr_i  input  32  instruction word returned combinationally for imem_addr_o in the same cycle.
- redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid_o  output  1  head entry valid.
- instr_o  output  32  head instruction; 0 when empty.
- pc_o  output  32  PC of head instruction; 0 when empty.
- pc_plus4_o  output  32  pc_o+4 (mod 2^32); 0 when empty.
- instr_ready_i  input  1  decode accepts head this cycle.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State: fetch_pc, rd_ptr, wr_ptr, count, DEPTH x {pc, instr} storage. Outputs derive from registered state only; no combinational path from redirect_i or instr_ready_i to any output.
- Reset (rst_i=1 at edge):
  - fetch_pc=RESET_PC, pointers=0, count=0.
  - Outputs then: instr_valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0, count_o=0, imem_addr_o=RESET_PC.
  - Reset overrides redirect, push and pop; a reset mid-stream discards all entries.
- pop = instr_valid_o & instr_ready_i.
- push = !redirect_i & (count<DEPTH | pop).
  - A push writes {fetch_pc, imem_instr_i} at wr_ptr and advances fetch_pc by 4 (wraps 32'hFFFF_FFFC -> 0).
  - When push=0 (full, no pop), fetch_pc holds and the same address is re-presented.
- Full with simultaneous pop: push and pop both occur; count stays DEPTH.
- Empty: instr_valid_o=0. instr_ready_i is ignored, and a push that cycle is visible the next cycle.
- Latency: an instruction pushed at edge N is at the head (instr_valid_o=1) after edge N if the queue was empty. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 instruction per cycle sustained when instr_ready_i stays 1.
- instr_valid_o = (count!=0). instr_o/pc_o read storage[rd_ptr] gated to 0 when count==0.
- Pointers wrap modulo DEPTH. count = count + push - pop.
- Redirect (redirect_i=1, rst_i=0):
  - A pop in the same cycle completes normally (decode consumed that head).
  - All other entries are discarded: count=0, rd_ptr=wr_ptr=0.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}. No push that cycle.
  - Next cycle: imem_addr_o=target, queue empty, target pushed. Target is valid one cycle after that.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- An instruction word of 0 (NOP / uninitialised memory) is queued like any other; no decoding in this block.

Test Plan:
- Reset then instr_ready_i=1, memory word i = 32'h1000_0000+i -> first edge after reset pushes PC 0. instr_valid_o=1 next cycle with instr_o=32'h1000_0000, pc_o=0, pc_plus4_o=4. Then one per cycle: pc_o=4,8,12…, count_o stays 1.
- instr_ready_i=0 from reset, DEPTH=4 -> count_o 1,2,3,4 then holds 4. imem_addr_o holds 16. Raising ready drains PCs 0,4,8,12 then 16 in order with no gap.
- Full (count=4), instr_ready_i=1 for one cycle -> pop of PC 0 and push of PC 16 in the same edge. count_o stays 4, next pc_o=4.
- Queue holds PCs 0..12, redirect_i=1, redirect_pc_i=32'h0000_0043, instr_ready_i=1 -> head PC 0 consumed. Next cycle count_o=0, instr_valid_o=0, imem_addr_o=32'h40. The cycle after, pc_o=32'h40 valid.
- rst_i=1 asserted while count=3 and redirect_i=1 -> after edge count_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, all data outputs 0.
- redirect_pc_i=32'hFFFF_FFF8, ready=1 -> consecutive pc_o values FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004. pc_plus4_o at FFFF_FFFC is 0.
